// File: rtl/sfp_vec.sv
// sfp_vec: per-lane saturating psum accumulator over depth entries; drain latency 1 cycle, 1 vector/cycle.
// Backpressure: in_ready only in ACC, out_data held while out_ready low. Optional ReLU on drain via SFP_RELU_EN.
module sfp_vec #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int VW     = PSUM_BW * COL
) (
    input  logic          clk,
    input  logic          reset,
`ifdef SFP_RELU_EN
    input  logic          relu_en,
`endif
    input  logic          cmd_acc,
    input  logic          first_pass,
    input  logic          cmd_drain,
    input  logic [AW-1:0] num_pix,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [VW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] out_data,
    output logic          busy,
    output logic          o_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_last;
    logic          r_first;
    logic          r_out_valid;
    logic [VW-1:0] r_out_data;
    logic          r_ovf;
    logic [VW-1:0] r_mem [DEPTH];

    logic [VW-1:0]  w_cur;
    logic [VW-1:0]  w_rd;
    logic [VW-1:0]  w_sat_vec;
    logic [VW-1:0]  w_rd_vec;
    logic [COL-1:0] w_hi;
    logic [COL-1:0] w_lo;
    logic           w_clamp;
    logic           w_drain_relu;
    logic [AW-1:0]  w_ptr_prev;

`ifdef SFP_RELU_EN
    logic r_relu;
    // The first drained vector is produced on the command edge, before r_relu is valid.
    assign w_drain_relu = (r_state == IDLE) ? relu_en : r_relu;
`else
    assign w_drain_relu = 1'b0;
`endif

    assign w_cur      = r_mem[r_ptr];
    assign w_rd       = r_mem[(r_state == IDLE) ? '0 : r_ptr];
    assign w_ptr_prev = r_ptr - AW'(1);
    assign w_clamp    = |(w_hi | w_lo);

    for (genvar g = 0; g < COL; g++) begin : g_lane
        logic [PSUM_BW-1:0] w_a;
        logic [PSUM_BW-1:0] w_b;
        logic [PSUM_BW:0]   w_sum;
        assign w_a   = w_cur[g*PSUM_BW +: PSUM_BW];
        assign w_b   = in_data[g*PSUM_BW +: PSUM_BW];
        assign w_sum = {w_a[PSUM_BW-1], w_a} + {w_b[PSUM_BW-1], w_b};
        // Top two bits of the widened sum disagree exactly when the result leaves the psum range.
        assign w_hi[g] = ~w_sum[PSUM_BW] &  w_sum[PSUM_BW-1];
        assign w_lo[g] =  w_sum[PSUM_BW] & ~w_sum[PSUM_BW-1];
        assign w_sat_vec[g*PSUM_BW +: PSUM_BW] =
            w_hi[g] ? {1'b0, {(PSUM_BW-1){1'b1}}} :
            w_lo[g] ? {1'b1, {(PSUM_BW-1){1'b0}}} : w_sum[PSUM_BW-1:0];
        assign w_rd_vec[g*PSUM_BW +: PSUM_BW] =
            (w_drain_relu && w_rd[(g+1)*PSUM_BW-1]) ? '0 : w_rd[g*PSUM_BW +: PSUM_BW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_last      <= '0;
            r_first     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
`ifdef SFP_RELU_EN
            r_relu      <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_acc) begin
                        r_state <= ACC;
                        r_first <= first_pass;
                        r_last  <= num_pix;
                        r_ptr   <= '0;
                        if (first_pass) r_ovf <= 1'b0;
                    end else if (cmd_drain) begin
                        r_state     <= DRAIN;
                        r_last      <= num_pix;
                        r_out_data  <= w_rd_vec;
                        r_out_valid <= 1'b1;
                        r_ptr       <= AW'(1);
`ifdef SFP_RELU_EN
                        r_relu      <= relu_en;
`endif
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        r_mem[r_ptr] <= r_first ? in_data : w_sat_vec;
                        if (!r_first && w_clamp) r_ovf <= 1'b1;
                        r_ptr <= r_ptr + AW'(1);
                        if (r_ptr == r_last) r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (w_ptr_prev == r_last) begin
                            r_out_valid <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_out_data <= w_rd_vec;
                            r_ptr      <= r_ptr + AW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ACC);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_sfp_vec.sv
// Self-checking bench for sfp_vec: saturation table, directed corner sequences, randomized passes vs. a lane-array model.
module tb_sfp_vec;
    localparam int COL = 8;
    localparam int P   = 16;
    localparam int D   = 16;
    localparam int VW  = P * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_acc, first_pass, cmd_drain;
    logic [3:0]    num_pix;
    logic          in_valid, in_ready;
    logic [VW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [VW-1:0] out_data;
    logic          busy, o_ovf;
`ifdef SFP_RELU_EN
    logic          relu_en;
`endif

    sfp_vec dut (
        .clk(clk), .reset(reset),
`ifdef SFP_RELU_EN
        .relu_en(relu_en),
`endif
        .cmd_acc(cmd_acc), .first_pass(first_pass), .cmd_drain(cmd_drain), .num_pix(num_pix),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            model [D][COL];
    bit            model_ovf;
    logic [VW-1:0] acc_vec [D];
    logic [VW-1:0] drained [$];
    logic [6:0]    vpat;

    typedef struct {
        int first_v;
        int add_v;
        int exp_v;
        bit exp_ovf;
    } sat_rec_t;
    sat_rec_t tbl [6];

    task automatic check(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(string name);
        checks++;
        failures++;
        $display("FAIL %s: condition not reached within bound", name);
    endtask

    function automatic int lane(logic [VW-1:0] v, int l);
        logic signed [P-1:0] t;
        t = v[P*l +: P];
        return int'(t);
    endfunction

    function automatic logic [VW-1:0] exp_vec(int idx, bit relu);
        logic [VW-1:0] r;
        int v;
        r = '0;
        for (int l = 0; l < COL; l++) begin
            v = model[idx][l];
            if (relu && v < 0) v = 0;
            r[P*l +: P] = v[P-1:0];
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int e = 0; e < D; e++)
            for (int l = 0; l < COL; l++) model[e][l] = 0;
        model_ovf = 0;
    endtask

    task automatic fill_rand(int np);
        int v;
        for (int b = 0; b <= np; b++)
            for (int l = 0; l < COL; l++) begin
                case ($urandom_range(0, 3))
                    0:       v = int'($urandom_range(0, 65535)) - 32768;
                    1:       v = int'($urandom_range(0, 200)) - 100;
                    2:       v = int'($urandom_range(30000, 32767));
                    default: v = -int'($urandom_range(30000, 32768));
                endcase
                acc_vec[b][P*l +: P] = v[P-1:0];
            end
    endtask

    // vmode: 0 random in_valid gaps, 1 always valid, 2 follow vpat (LSB first)
    task automatic feed_beats(bit first, int np, int vmode);
        int beat = 0;
        int cyc = 0;
        int s;
        bit v;
        while (beat <= np && cyc < 400) begin
            if (in_ready !== 1'b1) begin
                note_fail("acc_in_ready_high");
                break;
            end
            case (vmode)
                0:       v = ($urandom_range(0, 99) < 70);
                1:       v = 1'b1;
                default: v = (cyc < 7) ? vpat[cyc] : 1'b0;
            endcase
            in_valid = v;
            in_data  = acc_vec[beat];
            @(negedge clk);
            if (v) begin
                for (int l = 0; l < COL; l++) begin
                    if (first) s = lane(acc_vec[beat], l);
                    else begin
                        s = model[beat][l] + lane(acc_vec[beat], l);
                        if (s > 32767)  begin s = 32767;  model_ovf = 1; end
                        if (s < -32768) begin s = -32768; model_ovf = 1; end
                    end
                    model[beat][l] = s;
                end
                beat++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        if (beat <= np) note_fail("acc_beats_timeout");
        check("acc_done_in_ready", in_ready, 0);
        check("acc_done_busy", busy, 0);
    endtask

    task automatic do_acc(bit first, int np, int vmode);
        cmd_acc = 1'b1;
        first_pass = first;
        num_pix = 4'(np);
        @(negedge clk);
        cmd_acc = 1'b0;
        first_pass = 1'b0;
        if (first) model_ovf = 0;
        feed_beats(first, np, vmode);
    endtask

    // rpct < 0: hold out_ready low for cycles 1..3 (stall on beat 1)
    task automatic do_drain(int np, int rpct, bit relu, output int cycles);
        int idx = 0;
        int cyc = 0;
        bit r;
        drained.delete();
        cmd_drain = 1'b1;
        num_pix = 4'(np);
`ifdef SFP_RELU_EN
        relu_en = relu;
`endif
        @(negedge clk);
        cmd_drain = 1'b0;
        while (idx <= np && cyc < 400) begin
            if (out_valid !== 1'b1) begin
                note_fail("drain_out_valid_high");
                break;
            end
            check("drain_data", out_data, exp_vec(idx, relu));
            r = (rpct < 0) ? !(cyc >= 1 && cyc <= 3) : ($urandom_range(0, 99) < rpct);
            out_ready = r;
            if (r) drained.push_back(out_data);
            @(negedge clk);
            if (r) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        if (idx <= np) note_fail("drain_timeout");
        check("drain_done_out_valid", out_valid, 0);
        check("drain_done_busy", busy, 0);
        cycles = cyc;
    endtask

    initial begin
        int cyc;
        int t;
        logic [VW-1:0] dv;

        tbl[0] = '{32000,  1000,   32767, 1'b1};
        tbl[1] = '{-32000, -1000, -32768, 1'b1};
        tbl[2] = '{100,    -200,   -100,  1'b0};
        tbl[3] = '{32767,  0,      32767, 1'b0};
        tbl[4] = '{-32768, -1,    -32768, 1'b1};
        tbl[5] = '{-1,     1,      0,     1'b0};

        reset = 1'b1;
        cmd_acc = 0; first_pass = 0; cmd_drain = 0; num_pix = 0;
        in_valid = 0; in_data = '0; out_ready = 0; vpat = '0;
`ifdef SFP_RELU_EN
        relu_en = 0;
`endif
        clear_model();
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_out_data", out_data, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_drain(D - 1, 100, 0, cyc);

        // Accumulate-then-drain with lane0 ramp
        fill_rand(3);
        for (int b = 0; b < 4; b++) begin t = 10 * (b + 1); acc_vec[b][P-1:0] = t[P-1:0]; end
        do_acc(1, 3, 1);
        fill_rand(3);
        for (int b = 0; b < 4; b++) acc_vec[b][P-1:0] = 16'd5;
        do_acc(0, 3, 1);
        do_drain(3, 100, 0, cyc);
        check("t1_drain_cycles", cyc, 4);
        for (int b = 0; b < 4 && b < drained.size(); b++) begin
            dv = drained[b];
            t = 15 + 10 * b;
            check("t1_lane0", dv[P-1:0], t[P-1:0]);
        end

        // Saturation table: first load then add on a single entry
        for (int i = 0; i < 6; i++) begin
            for (int l = 0; l < COL; l++) begin t = tbl[i].first_v; acc_vec[0][P*l +: P] = t[P-1:0]; end
            do_acc(1, 0, 1);
            check("tbl_ovf_after_first", o_ovf, 0);
            for (int l = 0; l < COL; l++) begin t = tbl[i].add_v; acc_vec[0][P*l +: P] = t[P-1:0]; end
            do_acc(0, 0, 1);
            check("tbl_ovf", o_ovf, tbl[i].exp_ovf);
            do_drain(0, 100, 0, cyc);
            if (drained.size() > 0) begin
                dv = drained[0];
                t = tbl[i].exp_v;
                check("tbl_sat_lane0", dv[P-1:0], t[P-1:0]);
            end
        end

        // Stall on drained beat 1
        fill_rand(5);
        do_acc(1, 5, 1);
        do_drain(5, -1, 0, cyc);
        check("t3_beats", drained.size(), 6);
        check("t3_cycles", cyc, 9);

        // in_valid pattern 1,0,0,1,1,0,1
        vpat = 7'b1011001;
        fill_rand(3);
        do_acc(1, 3, 2);
        do_drain(3, 100, 0, cyc);

        // Simultaneous commands, command during ACC, reset mid-DRAIN
        cmd_acc = 1; cmd_drain = 1; first_pass = 1; num_pix = 4'd1;
        @(negedge clk);
        cmd_acc = 0; cmd_drain = 0; first_pass = 0;
        check("t5_acc_wins_in_ready", in_ready, 1);
        check("t5_acc_wins_out_valid", out_valid, 0);
        cmd_drain = 1;
        @(negedge clk);
        cmd_drain = 0;
        check("t5_drain_ignored_in_ready", in_ready, 1);
        check("t5_drain_ignored_out_valid", out_valid, 0);
        model_ovf = 0;
        fill_rand(1);
        feed_beats(1, 1, 1);
        do_drain(1, 100, 0, cyc);
        cmd_drain = 1; num_pix = 4'd3;
        @(negedge clk);
        cmd_drain = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0; reset = 1;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_out_data", out_data, '0);
        @(negedge clk);
        reset = 0;
        clear_model();
        @(negedge clk);
        do_drain(D - 1, 100, 0, cyc);

`ifdef SFP_RELU_EN
        acc_vec[0] = '0;
        acc_vec[0][P-1:0] = 16'hFFFB;
        acc_vec[0][2*P-1:P] = 16'd7;
        do_acc(1, 0, 1);
        do_drain(0, 100, 1, cyc);
        dv = drained[0];
        check("t6_relu_lane0", dv[P-1:0], 16'd0);
        check("t6_relu_lane1", dv[2*P-1:P], 16'd7);
        do_drain(0, 100, 0, cyc);
        dv = drained[0];
        check("t6_raw_lane0", dv[P-1:0], 16'hFFFB);
`endif

        // Randomized passes against the model
        for (int it = 0; it < 30; it++) begin
            int np;
            bit fp;
            bit rl;
            np = $urandom_range(0, D - 1);
            fp = (it == 0) || ($urandom_range(0, 2) == 0);
            fill_rand(np);
            do_acc(fp, np, $urandom_range(0, 1));
            check("rand_ovf", o_ovf, model_ovf);
            rl = 1'b0;
`ifdef SFP_RELU_EN
            rl = $urandom_range(0, 1);
`endif
            do_drain($urandom_range(0, D - 1), $urandom_range(30, 100), rl, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
